// File: rtl/imm_encoder_if.sv
// ---------------------------------------------------------------------------
// cpu_pkg / imm_encoder_if
//
// Purpose:
//   cpu_pkg carries the immediate-format selector shared by the instruction
//   builders. imm_encoder_if bundles the request and result handshakes of
//   the immediate encoder.
//
// Signals:
//   in_valid  / in_ready   request handshake
//   in_type                immediate format (IMM_I/S/B/U/J); other codes are illegal
//   in_imm                 immediate value, two's complement
//   in_base                instruction word supplying every non-immediate bit
//   out_valid / out_ready  result handshake
//   out_instr              encoded instruction word
//   out_err                immediate not representable, misaligned or illegal type
//
// Modports:
//   master  request producer / result consumer
//   slave   the encoder
// ---------------------------------------------------------------------------
package cpu_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;
endpackage

interface imm_encoder_if;
  import cpu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  imm_type_t   in_type;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_type, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_type, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//
// Purpose:
//   Packs a 32-bit immediate into the RV32I immediate field positions of a
//   base instruction word and flags values that cannot be represented
//   (range, alignment, illegal format). Two-stage valid/ready pipeline with
//   full backpressure: stage 1 captures the request, stage 2 holds the
//   encoded word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        imm_encoder_if.slave (request and result handshakes)
//   stat_enc   results delivered            (IMM_ENC_STATS_EN only)
//   stat_err   results delivered with error (IMM_ENC_STATS_EN only)
//
// Parameters:
//   CNT_W         statistics counter width (IMM_ENC_STATS_EN only)
//   STRICT_ALIGN  1: odd B/J immediates are errors; 0: bit 0 is dropped
//
// Configuration macro:
//   IMM_ENC_STATS_EN  adds the saturating stat_enc/stat_err counters.
// ---------------------------------------------------------------------------
module imm_encoder
  import cpu_pkg::*;
#(
`ifdef IMM_ENC_STATS_EN
  parameter int CNT_W        = 16,
`endif
  parameter bit STRICT_ALIGN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  imm_encoder_if.slave bus
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_enc,
  output logic [CNT_W-1:0] stat_err
`endif
);

  logic        s1Valid_q, s1Valid_d;
  imm_type_t   s1Type_q,  s1Type_d;
  logic [31:0] s1Imm_q,   s1Imm_d;
  logic [31:0] s1Base_q,  s1Base_d;

  logic        s2Valid_q, s2Valid_d;
  logic [31:0] s2Instr_q, s2Instr_d;
  logic        s2Err_q,   s2Err_d;

  logic        s2Adv;
  logic        inReady;
  logic [31:0] encInstr;
  logic        encErr;
  logic signed [31:0] immS;

  // Stage 2 can take a new entry when it is empty or its entry leaves this
  // cycle; stage 1 drains into stage 2 under the same condition.
  assign s2Adv   = !s2Valid_q || bus.out_ready;
  assign inReady = !s1Valid_q || s2Adv;

  assign bus.in_ready  = inReady;
  assign bus.out_valid = s2Valid_q;
  assign bus.out_instr = s2Instr_q;
  assign bus.out_err   = s2Err_q;

  // Field packing and range checks on the stage-1 entry. Bits outside the
  // selected field pass through from the base word; an erroneous immediate
  // still produces its truncated encoding.
  always_comb begin
    immS     = $signed(s1Imm_q);
    encInstr = s1Base_q;
    encErr   = 1'b0;
    case (s1Type_q)
      IMM_I: begin
        encInstr[31:20] = s1Imm_q[11:0];
        encErr = (immS < -32'sd2048) || (immS > 32'sd2047);
      end
      IMM_S: begin
        encInstr[31:25] = s1Imm_q[11:5];
        encInstr[11:7]  = s1Imm_q[4:0];
        encErr = (immS < -32'sd2048) || (immS > 32'sd2047);
      end
      IMM_B: begin
        encInstr[31]    = s1Imm_q[12];
        encInstr[7]     = s1Imm_q[11];
        encInstr[30:25] = s1Imm_q[10:5];
        encInstr[11:8]  = s1Imm_q[4:1];
        encErr = (immS < -32'sd4096) || (immS > 32'sd4094) ||
                 (STRICT_ALIGN && s1Imm_q[0]);
      end
      IMM_U: begin
        encInstr[31:12] = s1Imm_q[31:12];
        encErr = (s1Imm_q[11:0] != 12'd0);
      end
      IMM_J: begin
        encInstr[31]    = s1Imm_q[20];
        encInstr[19:12] = s1Imm_q[19:12];
        encInstr[20]    = s1Imm_q[11];
        encInstr[30:21] = s1Imm_q[10:1];
        encErr = (immS < -32'sd1048576) || (immS > 32'sd1048574) ||
                 (STRICT_ALIGN && s1Imm_q[0]);
      end
      default: begin
        encInstr = s1Base_q;
        encErr   = 1'b1;
      end
    endcase
  end

  // Next-state for both stages; a stalled stage keeps its entry untouched,
  // which also keeps the outputs stable under backpressure.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Type_d  = s1Type_q;
    s1Imm_d   = s1Imm_q;
    s1Base_d  = s1Base_q;
    s2Valid_d = s2Valid_q;
    s2Instr_d = s2Instr_q;
    s2Err_d   = s2Err_q;
    if (inReady) begin
      s1Valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1Type_d = bus.in_type;
        s1Imm_d  = bus.in_imm;
        s1Base_d = bus.in_base;
      end
    end
    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Instr_d = encInstr;
        s2Err_d   = encErr;
      end
    end
  end

  // Pipeline registers; reset discards any in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Type_q  <= IMM_I;
      s1Imm_q   <= '0;
      s1Base_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Instr_q <= '0;
      s2Err_q   <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Type_q  <= s1Type_d;
      s1Imm_q   <= s1Imm_d;
      s1Base_q  <= s1Base_d;
      s2Valid_q <= s2Valid_d;
      s2Instr_q <= s2Instr_d;
      s2Err_q   <= s2Err_d;
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic [CNT_W-1:0] statEnc_q, statEnc_d;
  logic [CNT_W-1:0] statErr_q, statErr_d;
  logic             outFire;

  assign outFire  = s2Valid_q && bus.out_ready;
  assign stat_enc = statEnc_q;
  assign stat_err = statErr_q;

  // Delivered-result counters stick at all-ones instead of wrapping.
  always_comb begin
    statEnc_d = statEnc_q;
    statErr_d = statErr_q;
    if (outFire && (statEnc_q != '1)) statEnc_d = statEnc_q + 1'b1;
    if (outFire && s2Err_q && (statErr_q != '1)) statErr_d = statErr_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statEnc_q <= '0;
      statErr_q <= '0;
    end else begin
      statEnc_q <= statEnc_d;
      statErr_q <= statErr_d;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// ---------------------------------------------------------------------------
// tb_imm_encoder
//
// Purpose:
//   Self-checking bench for imm_encoder (STRICT_ALIGN=1). Directed vectors
//   with hand-computed words, backpressure, reset-in-flight and a randomized
//   run scored against a per-bit reference model of the RV32I field layout.
// ---------------------------------------------------------------------------
module tb_imm_encoder;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  imm_encoder_if bus();

`ifdef IMM_ENC_STATS_EN
  logic [15:0] statEnc;
  logic [15:0] statErr;
`endif

  imm_encoder #(.STRICT_ALIGN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IMM_ENC_STATS_EN
    ,
    .stat_enc (statEnc),
    .stat_err (statErr)
`endif
  );

  typedef struct {
    imm_type_t   t;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  // Which immediate bit lands in instruction bit p, or -1 if p comes from base.
  function automatic int immBitFor(imm_type_t t, int p);
    case (t)
      IMM_I: return (p >= 20) ? p - 20 : -1;
      IMM_S: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
        return -1;
      end
      IMM_B: begin
        if (p == 31) return 12;
        if (p == 7) return 11;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        return -1;
      end
      IMM_U: return (p >= 12) ? p : -1;
      IMM_J: begin
        if (p == 31) return 20;
        if (p == 20) return 11;
        if (p >= 21) return p - 20;
        if (p >= 12) return p;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  // Reference result {err, instr}.
  function automatic logic [32:0] refEncode(imm_type_t t, logic [31:0] imm, logic [31:0] base);
    logic [31:0] w;
    int k;
    int v;
    logic e;
    w = base;
    v = $signed(imm);
    for (int p = 0; p < 32; p++) begin
      k = immBitFor(t, p);
      if (k >= 0) w[p] = imm[k];
    end
    case (t)
      IMM_I, IMM_S: e = (v < -2048) || (v > 2047);
      IMM_B: e = (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
      IMM_U: e = (imm[11:0] != 12'd0);
      IMM_J: e = (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
      default: e = 1'b1;
    endcase
    return {e, w};
  endfunction

  function automatic imm_type_t randType();
    int r;
    r = $urandom_range(0, 12);
    return (r < 10) ? imm_type_t'(3'(r % 5)) : imm_type_t'(3'(r - 5));
  endfunction

  function automatic logic [31:0] randImm();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 10000)) - 32'd5000;
      2: return $urandom & 32'hFFFFF000;
      default: return 32'($urandom_range(0, 2200000)) - 32'd1100000;
    endcase
  endfunction

  // Presents one request at a negedge and waits (bounded) for acceptance.
  task automatic applyStimulus(input imm_type_t t, input logic [31:0] imm,
                               input logic [31:0] base, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_type  = t;
    bus.in_imm   = imm;
    bus.in_base  = base;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (bus.in_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_type = IMM_I;
    bus.in_imm = '0;
    bus.in_base = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    compared++;
    if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_data: got instr=%h err=%b expected 00000000/0",
               bus.out_instr, bus.out_err);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    vec_t vecs[$];
    bit ok;
    vecs.push_back('{IMM_I, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0});
    vecs.push_back('{IMM_S, 32'h000007FF, 32'h00002023, 32'h7E002FA3, 1'b0});
    vecs.push_back('{IMM_S, 32'h00000800, 32'h00002023, 32'h80002023, 1'b1});
    vecs.push_back('{IMM_B, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0});
    vecs.push_back('{IMM_B, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1});
    vecs.push_back('{IMM_U, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0});
    vecs.push_back('{IMM_U, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1});
    vecs.push_back('{IMM_J, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1});
    vecs.push_back('{IMM_I, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0});
    vecs.push_back('{IMM_I, 32'hFFFFF7FF, 32'h00000013, 32'h7FF00013, 1'b1});
    vecs.push_back('{IMM_B, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0});
    vecs.push_back('{IMM_B, 32'h00000FFF, 32'h00000063, 32'h7E000FE3, 1'b1});
    vecs.push_back('{IMM_J, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0});
    vecs.push_back('{IMM_J, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0});
    vecs.push_back('{imm_type_t'(3'd5), 32'h00000123, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{IMM_I, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].t, vecs[i].imm, vecs[i].base, ok);
      compared++;
      if (!ok) begin
        mismatched++;
        $display("[TB] FAIL vec%0d_accept: got no accept expected accept", i);
        continue;
      end
      compared++;
      if (bus.out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL vec%0d_latency_early: got out_valid=%b one cycle after accept expected 0",
                 i, bus.out_valid);
      end
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== vecs[i].instr || bus.out_err !== vecs[i].err) begin
        mismatched++;
        $display("[TB] FAIL vec%0d_result: got valid=%b instr=%h err=%b expected 1/%h/%b",
                 i, bus.out_valid, bus.out_instr, bus.out_err, vecs[i].instr, vecs[i].err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] imms[3];
    logic [32:0] exps[3];
    int idx;
    imms[0] = 32'h00000123;
    imms[1] = 32'hFFFFF800;
    imms[2] = 32'h00001000;
    for (int i = 0; i < 3; i++) exps[i] = refEncode(IMM_I, imms[i], 32'h00000093 + 32'(i));
    idx = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) begin
        bus.in_valid = 1'b1;
        bus.in_type  = IMM_I;
        bus.in_imm   = imms[idx];
        bus.in_base  = 32'h00000093 + 32'(idx);
      end
      #1;
      if (c >= 2) begin
        compared++;
        if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== exps[0]) begin
          mismatched++;
          $display("[TB] FAIL stall_hold_c%0d: got valid=%b err=%b instr=%h expected 1/%h",
                   c, bus.out_valid, bus.out_err, bus.out_instr, exps[0]);
        end
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
    end
    #1;
    compared++;
    if (idx != 2 || bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_accept: got accepted=%0d in_ready=%b expected 2/0", idx, bus.in_ready);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (idx < 3) begin
        bus.in_valid = 1'b1;
        bus.in_imm   = imms[idx];
        bus.in_base  = 32'h00000093 + 32'(idx);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      compared++;
      if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== exps[k]) begin
        mismatched++;
        $display("[TB] FAIL release_order%0d: got valid=%b err=%b instr=%h expected 1/%h",
                 k, bus.out_valid, bus.out_err, bus.out_instr, exps[k]);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || idx != 3) begin
      mismatched++;
      $display("[TB] FAIL release_drain: got valid=%b accepted=%0d expected 0/3", bus.out_valid, idx);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_inflight;
    bit ok;
    logic [32:0] exp;
    bus.out_ready = 1'b0;
    bus.in_type = IMM_S;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.in_imm = 32'(c + 5);
      bus.in_base = 32'h00002023;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    compared++;
    if (bus.out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL inflight_setup: got out_valid=%b expected 1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got out_valid=%b in_ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
`ifdef IMM_ENC_STATS_EN
    compared++;
    if (statEnc !== 16'd0 || statErr !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", statEnc, statErr);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      compared++;
      if (bus.out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL post_reset_quiet%0d: got out_valid=%b expected 0", c, bus.out_valid);
      end
      @(negedge clk);
    end
    exp = refEncode(IMM_S, 32'hFFFFF810, 32'h00002023);
    applyStimulus(IMM_S, 32'hFFFFF810, 32'h00002023, ok);
    @(negedge clk);
    compared++;
    if (!ok || bus.out_valid !== 1'b1 || {bus.out_err, bus.out_instr} !== exp) begin
      mismatched++;
      $display("[TB] FAIL post_reset_txn: got ok=%b valid=%b err=%b instr=%h expected 1/1/%h",
               ok, bus.out_valid, bus.out_err, bus.out_instr, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [32:0] expQ[$];
    logic [32:0] exp;
    bit holdPrev;
    logic [31:0] prevInstr;
    logic prevErr;
    bit drain;
    holdPrev = 1'b0;
    prevInstr = '0;
    prevErr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drain = (c >= 360);
      bus.in_valid  = !drain && ($urandom_range(0, 3) != 0);
      bus.in_type   = randType();
      bus.in_imm    = randImm();
      bus.in_base   = $urandom;
      bus.out_ready = drain || ($urandom_range(0, 2) != 0);
      #1;
      if (holdPrev) begin
        compared++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== prevInstr || bus.out_err !== prevErr) begin
          mismatched++;
          $display("[TB] FAIL rand_hold_c%0d: got valid=%b instr=%h err=%b expected 1/%h/%b",
                   c, bus.out_valid, bus.out_instr, bus.out_err, prevInstr, prevErr);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL rand_spurious_c%0d: got output %h expected none", c, bus.out_instr);
        end else begin
          exp = expQ.pop_front();
          if ({bus.out_err, bus.out_instr} !== exp) begin
            mismatched++;
            $display("[TB] FAIL rand_result_c%0d: got err=%b instr=%h expected %h",
                     c, bus.out_err, bus.out_instr, exp);
          end
        end
      end
      holdPrev  = bus.out_valid && !bus.out_ready;
      prevInstr = bus.out_instr;
      prevErr   = bus.out_err;
      if (bus.in_valid && bus.in_ready)
        expQ.push_back(refEncode(bus.in_type, bus.in_imm, bus.in_base));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rand_lost: got %0d results outstanding expected 0", expQ.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
